// File: rtl/snes_vector_hook.sv
// SNES B-bus vector hook: overrides boot-ROM vector fetches from a small programmable table.
// Optional HOOK_REARM_EN: writing A5 to the pointer port re-enables every entry with a nonzero MATCH.
module snes_vector_hook #(
  parameter int         NUM_VEC  = 4,
  parameter logic [7:0] CFG_ADDR = 8'hF8,
  parameter logic [7:0] PTR_ADDR = 8'hF9,
  parameter logic [7:0] WIN_LO   = 8'h84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic       PARD_n,
  input  logic       PAWR_n,
  input  logic       bus_latch,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       ROM_oe_n,
  output logic       hook_busy
);
  localparam int         DEPTH  = NUM_VEC * 4;
  localparam int         PW     = $clog2(DEPTH);
  localparam int         CW     = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [7:0] DEPTH8 = 8'(DEPTH);

  typedef enum logic [1:0] {ARMED, LO, HI, DONE} state_t;

  // Per entry: [0] MATCH, [1] TGT_LO, [2] TGT_HI, [3] FLAGS {EN=bit0, ONESHOT=bit1}
  logic [NUM_VEC-1:0][3:0][7:0] tbl;
  logic [PW-1:0]                ptr, ptr_inc;
  logic [CW-1:0]                ent_ptr, cur, hit_idx;
  logic [NUM_VEC-1:0]           ent_hit;
  logic                         hit;
  state_t                       state, state_nx;
  logic                         wr_cfg, wr_ptr, rearm;
  logic [7:0]                   m, m1;
  logic                         ovr_lo, ovr_hi, rd_cfg, rd_ptr;

  assign wr_cfg  = bus_latch & ~PAWR_n & (addr == CFG_ADDR);
  assign wr_ptr  = bus_latch & ~PAWR_n & (addr == PTR_ADDR);
`ifdef HOOK_REARM_EN
  assign rearm   = wr_ptr & (data_in == 8'hA5);
`else
  assign rearm   = 1'b0;
`endif
  assign ent_ptr = CW'(ptr >> 2);
  assign ptr_inc = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

  genvar g;
  generate
    for (g = 0; g < NUM_VEC; g++) begin : g_match
      assign ent_hit[g] = tbl[g][3][0] & (addr == tbl[g][0]);
    end
  endgenerate

  // Descending scan so the lowest matching index is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_VEC - 1; i >= 0; i--) begin
      if (ent_hit[i]) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  assign m  = tbl[cur][0];
  assign m1 = m + 8'd1;

  always_comb begin
    state_nx = state;
    case (state)
      ARMED: if (bus_latch && hit) state_nx = LO;
      LO: if (bus_latch) begin
        if (addr == m1)     state_nx = HI;
        else if (addr != m) state_nx = ARMED;
      end
      HI:    if (bus_latch && addr != m1) state_nx = DONE;
      DONE:  state_nx = ARMED;
      default: state_nx = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARMED;
      cur   <= '0;
    end else begin
      state <= state_nx;
      if (state == ARMED && bus_latch && hit) cur <= hit_idx;
    end
  end

  // Table and pointer; the config write is placed after the one-shot clear so it wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl       <= '0;
      tbl[0][0] <= 8'hFC;
      tbl[0][1] <= 8'h84;
      tbl[0][2] <= 8'h21;
      tbl[0][3] <= 8'h03;
      ptr       <= '0;
    end else begin
      if (state == DONE && tbl[cur][3][1]) tbl[cur][3][0] <= 1'b0;
      if (wr_cfg) begin
        tbl[ent_ptr][ptr[1:0]] <= (ptr[1:0] == 2'd3) ? (data_in & 8'h03) : data_in;
        ptr <= ptr_inc;
      end
      if (rearm) begin
        for (int i = 0; i < NUM_VEC; i++)
          if (tbl[i][0] != 8'h00) tbl[i][3][0] <= 1'b1;
      end else if (wr_ptr) begin
        ptr <= PW'(data_in % DEPTH8);
      end
    end
  end

  assign ovr_lo = (state == LO || state == HI) && (addr == m);
  assign ovr_hi = (state == LO || state == HI) && (addr == m1);
  assign rd_cfg = ~PARD_n & (addr == CFG_ADDR);
  assign rd_ptr = ~PARD_n & (addr == PTR_ADDR);

  always_comb begin
    data_oe  = 1'b0;
    data_out = 8'h00;
    ROM_oe_n = 1'b1;
    if (ovr_lo) begin
      data_oe  = 1'b1;
      data_out = tbl[cur][1];
    end else if (ovr_hi) begin
      data_oe  = 1'b1;
      data_out = tbl[cur][2];
    end else if (rd_cfg) begin
      data_oe  = 1'b1;
      data_out = tbl[ent_ptr][ptr[1:0]];
    end else if (rd_ptr) begin
      data_oe  = 1'b1;
      data_out = 8'(ptr);
    end else if (~PARD_n && addr >= WIN_LO && addr <= 8'hF7) begin
      ROM_oe_n = 1'b0;
    end
  end

  assign hook_busy = (state == LO) || (state == HI);
endmodule

// File: tb/tb_snes_vector_hook.sv
// Directed bench for snes_vector_hook; inputs change on the falling edge, outputs checked there.
module tb_snes_vector_hook;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr, data_in;
  logic       PARD_n, PAWR_n, bus_latch;
  logic [7:0] data_out;
  logic       data_oe, ROM_oe_n, hook_busy;
  int         checks = 0;
  int         errors = 0;

  snes_vector_hook dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .PARD_n(PARD_n),
    .PAWR_n(PAWR_n), .bus_latch(bus_latch), .data_out(data_out), .data_oe(data_oe),
    .ROM_oe_n(ROM_oe_n), .hook_busy(hook_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge
  task automatic latch(input logic [7:0] a);
    addr = a; PAWR_n = 1'b1; bus_latch = 1'b1;
    @(negedge clk);
    bus_latch = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; PAWR_n = 1'b0; bus_latch = 1'b1;
    @(negedge clk);
    bus_latch = 1'b0; PAWR_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    PARD_n = 1'b0; addr = a;
    #1;
    chk(tag, data_out, exp);
    chk({tag, "_oe"}, {7'b0, data_oe}, 8'h01);
    PARD_n = 1'b1;
  endtask

  initial begin
    rst = 1'b1; addr = 8'h00; data_in = 8'h00;
    PARD_n = 1'b1; PAWR_n = 1'b1; bus_latch = 1'b0;
    #1;
    chk("rst_oe", {7'b0, data_oe}, 8'h00);
    chk("rst_dout", data_out, 8'h00);
    chk("rst_rom", {7'b0, ROM_oe_n}, 8'h01);
    chk("rst_busy", {7'b0, hook_busy}, 8'h00);
    rd_chk("rst_match0", 8'hF8, 8'hFC);
    @(negedge clk);
    rst = 1'b0;

    // Reset hook: FC -> 84, FD -> 21, then one-shot disables it
    latch(8'hFC);
    chk("hook_lo", data_out, 8'h84);
    chk("hook_lo_oe", {7'b0, data_oe}, 8'h01);
    chk("hook_lo_busy", {7'b0, hook_busy}, 8'h01);
    latch(8'hFD);
    chk("hook_hi", data_out, 8'h21);
    chk("hook_hi_busy", {7'b0, hook_busy}, 8'h01);
    latch(8'h10);
    chk("exit_busy", {7'b0, hook_busy}, 8'h00);
    chk("exit_oe", {7'b0, data_oe}, 8'h00);
    wr(8'hF9, 8'h03);
    rd_chk("oneshot_flags", 8'hF8, 8'h02);
    latch(8'hFC);
    chk("repeat_busy", {7'b0, hook_busy}, 8'h00);
    chk("repeat_oe", {7'b0, data_oe}, 8'h00);

`ifdef HOOK_REARM_EN
    wr(8'hF9, 8'hA5);
    rd_chk("rearm_ptr", 8'hF9, 8'h03);
    latch(8'hFC);
    chk("rearm_lo", data_out, 8'h84);
    latch(8'hFD);
    chk("rearm_hi", data_out, 8'h21);
    latch(8'h10);
    wr(8'hF9, 8'h03);
    rd_chk("rearm_flags", 8'hF8, 8'h02);
`else
    wr(8'hF9, 8'hA5);
    rd_chk("a5_ptr", 8'hF9, 8'h05);
    latch(8'hFC);
    chk("a5_busy", {7'b0, hook_busy}, 8'h00);
`endif

    // Entry 1: F0 -> 0090, not one-shot
    wr(8'hF9, 8'h04);
    wr(8'hF8, 8'hF0); wr(8'hF8, 8'h00); wr(8'hF8, 8'h90); wr(8'hF8, 8'h01);
    latch(8'hEA);
    chk("nomatch_ea", {7'b0, hook_busy}, 8'h00);
    latch(8'hEB);
    chk("nomatch_eb", {7'b0, hook_busy}, 8'h00);
    latch(8'hF0);
    chk("e1_lo", data_out, 8'h00);
    chk("e1_lo_oe", {7'b0, data_oe}, 8'h01);
    latch(8'hF1);
    chk("e1_hi", data_out, 8'h90);
    latch(8'h22);
    wr(8'hF9, 8'h07);
    rd_chk("e1_flags", 8'hF8, 8'h01);

    // Both entries match EA: lowest index wins
    wr(8'hF9, 8'h00); wr(8'hF8, 8'hEA);
    wr(8'hF9, 8'h03); wr(8'hF8, 8'h01);
    wr(8'hF9, 8'h04); wr(8'hF8, 8'hEA);
    latch(8'hEA);
    chk("prio_lo", data_out, 8'h84);
    latch(8'hEB);
    chk("prio_hi", data_out, 8'h21);
    latch(8'h30);
    chk("prio_exit", {7'b0, hook_busy}, 8'h00);

    // Aborted fetch: FC, FC, 30 keeps EN
    wr(8'hF9, 8'h00); wr(8'hF8, 8'hFC);
    wr(8'hF9, 8'h03); wr(8'hF8, 8'h03);
    latch(8'hFC);
    chk("abort_lo", {7'b0, hook_busy}, 8'h01);
    latch(8'hFC);
    chk("abort_stay", data_out, 8'h84);
    latch(8'h30);
    chk("abort_busy", {7'b0, hook_busy}, 8'h00);
    wr(8'hF9, 8'h03);
    rd_chk("abort_flags", 8'hF8, 8'h03);

    // Config write to FLAGS during DONE beats the one-shot clear
    latch(8'hFC); latch(8'hFD); latch(8'h10);
    wr(8'hF8, 8'h03);
    wr(8'hF9, 8'h03);
    rd_chk("done_race", 8'hF8, 8'h03);

    // ROM window and readback
    PARD_n = 1'b0; addr = 8'h90; #1;
    chk("rom_90", {7'b0, ROM_oe_n}, 8'h00);
    chk("rom_90_oe", {7'b0, data_oe}, 8'h00);
    addr = 8'hF7; #1;
    chk("rom_f7", {7'b0, ROM_oe_n}, 8'h00);
    addr = 8'h83; #1;
    chk("rom_83", {7'b0, ROM_oe_n}, 8'h01);
    addr = 8'hF8; #1;
    chk("rom_cfg", {7'b0, ROM_oe_n}, 8'h01);
    PARD_n = 1'b1; addr = 8'h90; #1;
    chk("rom_nord", {7'b0, ROM_oe_n}, 8'h01);
    @(negedge clk);
    wr(8'hF9, 8'h02);
    rd_chk("rb_tgthi", 8'hF8, 8'h21);
    rd_chk("rb_ptr", 8'hF9, 8'h02);

    // Pointer wrap, modulo load, FLAGS upper bits
    wr(8'hF9, 8'h0F); wr(8'hF8, 8'hFF);
    rd_chk("ptr_wrap", 8'hF9, 8'h00);
    wr(8'hF9, 8'h0F);
    rd_chk("flags_mask", 8'hF8, 8'h03);
    wr(8'hF9, 8'h13);
    rd_chk("ptr_mod", 8'hF9, 8'h03);

    // Reset mid-override
    latch(8'hFC);
    chk("pre_rst_oe", {7'b0, data_oe}, 8'h01);
    rst = 1'b1; #1;
    chk("rst_mid_oe", {7'b0, data_oe}, 8'h00);
    chk("rst_mid_busy", {7'b0, hook_busy}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wr(8'hF9, 8'h04);
    rd_chk("rst_e1_match", 8'hF8, 8'h00);
    wr(8'hF9, 8'h0F);
    rd_chk("rst_e3_flags", 8'hF8, 8'h00);
    wr(8'hF9, 8'h03);
    rd_chk("rst_e0_flags", 8'hF8, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/snes_vector_hook.md
SNES_VECTOR_HOOK -- requirements
Module: snes_vector_hook

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, meaning the number of hookable vector entries (1..8).
REQ-002 SHALL have parameter CFG_ADDR, default 8'hF8, meaning the B-bus address of the table data port.
REQ-003 SHALL have parameter PTR_ADDR, default 8'hF9, meaning the B-bus address of the table pointer register.
REQ-004 SHALL have parameter WIN_LO, default 8'h84, meaning the lowest B-bus address of the boot-ROM window.
REQ-005 SHALL have the ports clk  input  1  (40 MHz system clock) and rst  input  1  (reset, asynchronous, active-high).
REQ-006 SHALL have the ports addr  input  8  (raw SNES address low byte), data_in  input  8  (raw data bus), PARD_n  input  1  (B-bus read, active low) and PAWR_n  input  1  (B-bus write, active low).
REQ-007 SHALL have the port bus_latch  input  1  (one-clk pulse marking a settled address change, from snes_bus_sync).
REQ-008 SHALL have the ports data_out  output  8  (override/readback byte), data_oe  output  1  (drive enable for data_out), ROM_oe_n  output  1  (boot-ROM output enable, active low) and hook_busy  output  1  (high while a vector override is in progress).

Function
REQ-009 Table: NUM_VEC entries of 4 bytes each: MATCH (vector low-address byte), TGT_LO, TGT_HI and FLAGS (bit0 EN, bit1 ONESHOT, bits7:2 read as 0).
REQ-010 Config write: on bus_latch with ~PAWR_n and addr==CFG_ADDR, data_in is written to byte ptr; ptr then increments, wrapping from NUM_VEC*4-1 to 0.
REQ-011 Pointer write: on bus_latch with ~PAWR_n and addr==PTR_ADDR, ptr is loaded with data_in modulo NUM_VEC*4.
REQ-012 Readback: combinationally, ~PARD_n with addr==CFG_ADDR gives data_oe=1 and data_out=table[ptr], with no increment; ~PARD_n with addr==PTR_ADDR gives data_out=ptr.
REQ-013 FSM states: ARMED, LO, HI and DONE (DONE is a one-cycle exit state).
REQ-014 ARMED: on bus_latch, the lowest index i with EN[i] and addr==MATCH[i] moves the FSM to LO and latches cur=i; with no match, the FSM stays in ARMED.
REQ-015 LO: on bus_latch with addr==MATCH[cur]+1 (8-bit wrap), the FSM moves to HI; on bus_latch with any other address except MATCH[cur], it returns to ARMED (aborted fetch) with no ONESHOT clear.
REQ-016 HI: on bus_latch with addr!=MATCH[cur]+1, the FSM moves to DONE.
REQ-017 DONE: if ONESHOT[cur], EN[cur] is cleared; the FSM moves to ARMED next clk.
REQ-018 Override drive in LO or HI: addr==MATCH[cur] gives data_oe=1 and data_out=TGT_LO[cur]; addr==MATCH[cur]+1 gives data_oe=1 and data_out=TGT_HI[cur]; override does not depend on PARD_n.
REQ-019 Priority: override drive (REQ-018), then readback (REQ-012), then ROM window.
REQ-020 ROM window: ~PARD_n and WIN_LO<=addr<=8'hF7 gives ROM_oe_n=0 unless override or readback is active.
REQ-021 hook_busy SHALL be 1 in states LO and HI, and 0 otherwise.
REQ-022 A config write to the entry cur while the FSM is in LO or HI takes effect immediately on the override data.
REQ-023 A simultaneous DONE ONESHOT clear and a config write to the same FLAGS byte resolves with the config write winning.
REQ-024 Idle outputs SHALL be data_oe=0, data_out=0 and ROM_oe_n=1.

Reset
REQ-025 rst SHALL asynchronously force the FSM to ARMED and set ptr=0 and cur=0.
REQ-026 rst SHALL load entry 0 with MATCH=FC, TGT=2184 and FLAGS=03 (enabled, one-shot); entries 1..NUM_VEC-1 SHALL reset to all zero (disabled).
REQ-027 rst asserted mid-override SHALL drop data_oe the same instant; the table SHALL return to reset values.

Configuration
REQ-028 With HOOK_REARM_EN defined, a write of data_in==8'hA5 to PTR_ADDR SHALL set EN on every entry whose MATCH!=0 and leave ptr unchanged; with HOOK_REARM_EN undefined, that write SHALL be an ordinary pointer load and EN SHALL be restorable only via config write or rst.

Verification
REQ-029 Reset, bus_latch at FC then FD then 10 -> data_out 84 then 21; after the exit, EN[0]=0 and a repeat FC is not overridden.
REQ-030 Write ptr=04 and data F0,00,90,01 to CFG_ADDR, then addr EA/EB (fails to match) and F0/F1 -> data_out 00/90 and EN[1] stays 1 (not one-shot).
REQ-031 Entry 0 and entry 1 both MATCH=EA and enabled, addr EA -> cur=0 and TGT of entry 0 is driven.
REQ-032 FSM in LO, addr goes FC then 30 -> FSM returns to ARMED and EN[0] remains 1.
REQ-033 ~PARD_n at addr 90 -> ROM_oe_n=0; at CFG_ADDR with ptr=02 -> data_out=21 and data_oe=1.
REQ-034 HOOK_REARM_EN defined: after the reset hook completes, write A5 to PTR_ADDR then FC/FD -> 84/21 is overridden again.
